// File: rtl/wdt_pkg.sv
// wdt_pkg: shared state encoding and sizing helper for the watchdog reset controller.
//   state_t  : IDLE=0, WARN=1, RESET=2, HOLD=3 (also the state_o debug encoding)
//   max3     : largest of three phase lengths, used to size the shared counter
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARN  = 2'd1,
        RESET = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/wdt_down_cnt.sv
// wdt_down_cnt: loadable down-counter that stops at zero.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   dec       : decrement by one while non-zero
//   load_val  : W-bit reload value
//   zero      : count is zero
module wdt_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wdt_reset_ctrl.sv
// wdt_reset_ctrl: turns watchdog barks into a warning irq, then an escalated timed reset.
//   clk, rst     : clock, synchronous active-high power-on reset
//   wdt_i        : timeout pulse from the watchdog timer
//   ack_i        : software acknowledge of the warning
//   cause_clr_i  : clears the sticky reset cause
//   irq_o        : warning interrupt, high throughout WARN
//   sys_rst_o    : system reset request, high throughout RESET
//   kick_o       : restarts the watchdog timer (one cycle after ack, and all of HOLD)
//   cause_o      : sticky flag, last system reset was watchdog-initiated
//   bark_cnt_o   : saturating count of IDLE->WARN entries
//   state_o      : current state code
module wdt_reset_ctrl
    import wdt_pkg::*;
#(
    parameter int GRACE_CYCLES = 1024,
    parameter int RST_CYCLES   = 16,
    parameter int HOLD_CYCLES  = 8,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wdt_i,
    input  logic             ack_i,
    input  logic             cause_clr_i,
    output logic             irq_o,
    output logic             sys_rst_o,
    output logic             kick_o,
    output logic             cause_o,
    output logic [CNT_W-1:0] bark_cnt_o,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(max3(GRACE_CYCLES, RST_CYCLES, HOLD_CYCLES) + 1);

    state_t        state, nxt;
    logic          load, zero;
    logic [CW-1:0] load_val;

    // Each timed state is entered with its length minus one so that the
    // zero flag marks the last cycle of the phase.
    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE: if (wdt_i) begin
                nxt      = WARN;
                load     = 1'b1;
                load_val = CW'(GRACE_CYCLES - 1);
            end
            WARN: if (ack_i) begin
                nxt = IDLE;
            end else if (zero) begin
                nxt      = RESET;
                load     = 1'b1;
                load_val = CW'(RST_CYCLES - 1);
            end
            RESET: if (zero) begin
                nxt      = HOLD;
                load     = 1'b1;
                load_val = CW'(HOLD_CYCLES - 1);
            end
            HOLD: if (zero) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    wdt_down_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dec      (!load),
        .load_val (load_val),
        .zero     (zero)
    );

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            irq_o      <= 1'b0;
            sys_rst_o  <= 1'b0;
            kick_o     <= 1'b0;
            cause_o    <= 1'b0;
            bark_cnt_o <= '0;
        end else begin
            state     <= nxt;
            irq_o     <= (nxt == WARN);
            sys_rst_o <= (nxt == RESET);
            kick_o    <= (nxt == HOLD) || (state == WARN && ack_i);
            if (nxt == RESET && state != RESET)
                cause_o <= 1'b1;
            else if (cause_clr_i)
                cause_o <= 1'b0;
            if (state == IDLE && wdt_i && bark_cnt_o != '1)
                bark_cnt_o <= bark_cnt_o + 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// tb_wdt_reset_ctrl: directed self-checking bench for wdt_reset_ctrl (GRACE=8, RST=4, HOLD=2, CNT_W=2).
module tb_wdt_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wdt_i = 1'b0;
    logic       ack_i = 1'b0;
    logic       cause_clr_i = 1'b0;
    logic       irq_o, sys_rst_o, kick_o, cause_o;
    logic [1:0] bark_cnt_o;
    logic [1:0] state_o;

    int pass_n = 0;
    int total_n = 0;
    int irq_n, rst_n, kick_n;

    wdt_reset_ctrl #(
        .GRACE_CYCLES (8),
        .RST_CYCLES   (4),
        .HOLD_CYCLES  (2),
        .CNT_W        (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wdt_i       (wdt_i),
        .ack_i       (ack_i),
        .cause_clr_i (cause_clr_i),
        .irq_o       (irq_o),
        .sys_rst_o   (sys_rst_o),
        .kick_o      (kick_o),
        .cause_o     (cause_o),
        .bark_cnt_o  (bark_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each edge and tallying output-high cycles.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            irq_n  += int'(irq_o);
            rst_n  += int'(sys_rst_o);
            kick_n += int'(kick_o);
        end
    endtask

    task automatic clr_tally();
        irq_n = 0; rst_n = 0; kick_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(2);
        total_n++; if (irq_o !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq_o); else pass_n++;
        total_n++; if (sys_rst_o !== 1'b0) $display("FAIL rst_sysrst: got %b want 0", sys_rst_o); else pass_n++;
        total_n++; if (kick_o !== 1'b0) $display("FAIL rst_kick: got %b want 0", kick_o); else pass_n++;
        total_n++; if (cause_o !== 1'b0) $display("FAIL rst_cause: got %b want 0", cause_o); else pass_n++;
        total_n++; if (bark_cnt_o !== 2'd0) $display("FAIL rst_bark: got %0d want 0", bark_cnt_o); else pass_n++;
        total_n++; if (state_o !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_o); else pass_n++;
        rst = 1'b0;
        run(1);
    endtask

    task automatic test_ack();
        clr_tally();
        wdt_i = 1'b1; run(1); wdt_i = 1'b0;
        total_n++; if (irq_o !== 1'b1) $display("FAIL ack_irq_lat: got %b want 1", irq_o); else pass_n++;
        run(2);
        ack_i = 1'b1; run(1); ack_i = 1'b0;
        total_n++; if (kick_o !== 1'b1) $display("FAIL ack_kick_now: got %b want 1", kick_o); else pass_n++;
        run(5);
        total_n++; if (irq_n !== 3) $display("FAIL ack_irq_cycles: got %0d want 3", irq_n); else pass_n++;
        total_n++; if (kick_n !== 1) $display("FAIL ack_kick_cycles: got %0d want 1", kick_n); else pass_n++;
        total_n++; if (rst_n !== 0) $display("FAIL ack_sysrst_cycles: got %0d want 0", rst_n); else pass_n++;
        total_n++; if (bark_cnt_o !== 2'd1) $display("FAIL ack_bark: got %0d want 1", bark_cnt_o); else pass_n++;
        total_n++; if (state_o !== 2'd0) $display("FAIL ack_state: got %0d want 0", state_o); else pass_n++;
    endtask

    task automatic test_escalation();
        clr_tally();
        wdt_i = 1'b1; run(1); wdt_i = 1'b0;
        total_n++; if (state_o !== 2'd1) $display("FAIL esc_warn_state: got %0d want 1", state_o); else pass_n++;
        run(8);
        total_n++; if (state_o !== 2'd2) $display("FAIL esc_reset_state: got %0d want 2", state_o); else pass_n++;
        total_n++; if (sys_rst_o !== 1'b1) $display("FAIL esc_sysrst: got %b want 1", sys_rst_o); else pass_n++;
        total_n++; if (cause_o !== 1'b1) $display("FAIL esc_cause: got %b want 1", cause_o); else pass_n++;
        run(4);
        total_n++; if (state_o !== 2'd3) $display("FAIL esc_hold_state: got %0d want 3", state_o); else pass_n++;
        total_n++; if ({sys_rst_o, kick_o} !== 2'b01) $display("FAIL esc_hold_out: got %b want 01", {sys_rst_o, kick_o}); else pass_n++;
        run(2);
        total_n++; if (state_o !== 2'd0) $display("FAIL esc_idle_state: got %0d want 0", state_o); else pass_n++;
        run(3);
        total_n++; if (irq_n !== 8) $display("FAIL esc_irq_cycles: got %0d want 8", irq_n); else pass_n++;
        total_n++; if (rst_n !== 4) $display("FAIL esc_sysrst_cycles: got %0d want 4", rst_n); else pass_n++;
        total_n++; if (kick_n !== 2) $display("FAIL esc_kick_cycles: got %0d want 2", kick_n); else pass_n++;
        total_n++; if (bark_cnt_o !== 2'd2) $display("FAIL esc_bark: got %0d want 2", bark_cnt_o); else pass_n++;
    endtask

    task automatic test_tie();
        clr_tally();
        wdt_i = 1'b1; run(1); wdt_i = 1'b0;
        run(7);
        ack_i = 1'b1; run(1); ack_i = 1'b0;
        run(10);
        total_n++; if (irq_n !== 8) $display("FAIL tie_irq_cycles: got %0d want 8", irq_n); else pass_n++;
        total_n++; if (rst_n !== 0) $display("FAIL tie_sysrst_cycles: got %0d want 0", rst_n); else pass_n++;
        total_n++; if (kick_n !== 1) $display("FAIL tie_kick_cycles: got %0d want 1", kick_n); else pass_n++;
        total_n++; if (bark_cnt_o !== 2'd3) $display("FAIL tie_bark: got %0d want 3", bark_cnt_o); else pass_n++;
    endtask

    task automatic test_saturation();
        rst = 1'b1; run(1); rst = 1'b0; run(1);
        for (int i = 1; i <= 5; i++) begin
            wdt_i = 1'b1; run(1); wdt_i = 1'b0;
            ack_i = 1'b1; run(1); ack_i = 1'b0;
            run(1);
            total_n++;
            if (bark_cnt_o !== 2'((i > 3) ? 3 : i))
                $display("FAIL sat_bark%0d: got %0d want %0d", i, bark_cnt_o, (i > 3) ? 3 : i);
            else
                pass_n++;
        end
    endtask

    task automatic test_ignore();
        rst = 1'b1; run(1); rst = 1'b0; run(1);
        clr_tally();
        wdt_i = 1'b1; run(14); wdt_i = 1'b0;
        total_n++; if (state_o !== 2'd3) $display("FAIL ign_hold_state: got %0d want 3", state_o); else pass_n++;
        run(3);
        total_n++; if (bark_cnt_o !== 2'd1) $display("FAIL ign_bark: got %0d want 1", bark_cnt_o); else pass_n++;
        total_n++; if (irq_n !== 8) $display("FAIL ign_irq_cycles: got %0d want 8", irq_n); else pass_n++;
        total_n++; if (kick_n !== 2) $display("FAIL ign_kick_cycles: got %0d want 2", kick_n); else pass_n++;
        total_n++; if (state_o !== 2'd0) $display("FAIL ign_idle_state: got %0d want 0", state_o); else pass_n++;
    endtask

    task automatic test_cause();
        cause_clr_i = 1'b1; run(1); cause_clr_i = 1'b0;
        total_n++; if (cause_o !== 1'b0) $display("FAIL cause_pre_clr: got %b want 0", cause_o); else pass_n++;
        wdt_i = 1'b1; run(1); wdt_i = 1'b0;
        run(7);
        cause_clr_i = 1'b1; run(1); cause_clr_i = 1'b0;
        total_n++; if (state_o !== 2'd2) $display("FAIL cause_entry_state: got %0d want 2", state_o); else pass_n++;
        total_n++; if (cause_o !== 1'b1) $display("FAIL cause_tie: got %b want 1", cause_o); else pass_n++;
        run(10);
        total_n++; if (cause_o !== 1'b1) $display("FAIL cause_sticky: got %b want 1", cause_o); else pass_n++;
        cause_clr_i = 1'b1; run(1); cause_clr_i = 1'b0;
        total_n++; if (cause_o !== 1'b0) $display("FAIL cause_clr: got %b want 0", cause_o); else pass_n++;
    endtask

    task automatic test_reset_mid();
        wdt_i = 1'b1; run(1); wdt_i = 1'b0;
        run(9);
        total_n++; if (sys_rst_o !== 1'b1) $display("FAIL mid_pre_sysrst: got %b want 1", sys_rst_o); else pass_n++;
        rst = 1'b1; run(1); rst = 1'b0;
        total_n++; if (state_o !== 2'd0) $display("FAIL mid_state: got %0d want 0", state_o); else pass_n++;
        total_n++; if (sys_rst_o !== 1'b0) $display("FAIL mid_sysrst: got %b want 0", sys_rst_o); else pass_n++;
        total_n++; if (cause_o !== 1'b0) $display("FAIL mid_cause: got %b want 0", cause_o); else pass_n++;
        run(6);
        total_n++; if (state_o !== 2'd0) $display("FAIL mid_stays_idle: got %0d want 0", state_o); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_ack();
        test_escalation();
        test_tie();
        test_saturation();
        test_ignore();
        test_cause();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
